fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch front end that drives the synchronous instruction memory and presents PC/instruction to the execute stage. It consumes the hazard unit's stall (cwe2, active-high advance enable) and flush (noop) outputs, plus the X-stage redirect. It owns the PC register, the NOP-bubble injection and a one-entry hold buffer so that stalls never re-read memory.

Parameters:
RESET_PC, 32'h0000_0000, first instruction address fetched after reset
NOP_INST, 32'h0000_0013, instruction injected into X on bubbles (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous assert, active-low
cwe2  input  1  1 = pipeline advances; 0 = hold F and X
noop  input  1  1 = X sees a bubble next cycle
redirect  input  1  X-stage branch taken / jump
redirect_pc  input  32  redirect target
imem_addr  output  32  instruction memory address (combinational)
imem_re  output  1  instruction memory read enable
imem_rdata  input  32  memory data, valid one cycle after addr+re
inst_X  output  32  instruction to execute stage
pc_X  output  32  PC of inst_X
valid_X  output  1  inst_X is a real instruction

Behaviour:
- Sync memory: rdata at cycle t+1 = mem[imem_addr at t] when imem_re=1 at t; otherwise rdata is undefined.
- Registers: pc_F (address issued last cycle), hold_inst, state.
- FSM states: BOOT, RUN, HOLD, KILL.
- Reset (rst=0, asynchronous): state=BOOT, pc_F=RESET_PC, hold_inst=NOP_INST. Outputs while in reset: valid_X=0, inst_X=NOP_INST, pc_X=RESET_PC, imem_re=0.
- BOOT: imem_addr=RESET_PC, imem_re=1, valid_X=0. Next state RUN; pc_F stays RESET_PC. First real instruction reaches X exactly 2 edges after rst deasserts.
- RUN:
  - inst_X=imem_rdata, pc_X=pc_F, valid_X=1.
  - Next address = redirect ? redirect_pc : pc_F+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
- Address issue, cwe2=1:
  - imem_addr = next address, imem_re=1, pc_F <= next address.
  - noop=1 → next state KILL, else RUN.
- Address issue, cwe2=0:
  - imem_re=0, imem_addr=pc_F, pc_F unchanged, hold_inst <= current inst_X.
  - noop=1 → KILL, else HOLD.
- HOLD: inst_X=hold_inst, pc_X=pc_F, valid_X=1. Same cwe2/noop rules as RUN, except hold_inst is not re-captured. On cwe2=1, release takes effect that cycle: X consumes the held word and the next address issues.
- KILL: inst_X=NOP_INST, valid_X=0, pc_X=pc_F.
  - If entered with cwe2=0 (load-use bubble): the held word is kept in hold_inst. Leaving KILL returns to HOLD when cwe2=0, or to RUN with inst from hold_inst for one cycle when cwe2=1.
  - If entered with cwe2=1: leaves to RUN when cwe2=1, or HOLD when cwe2=0.
  - noop=1 while in KILL → remain KILL.
- Redirect ignored while cwe2=0; the hazard unit guarantees redirect only with cwe2=1. Redirect without noop is legal; the wrong-path word in flight is not killed.
- Misaligned redirect_pc[1:0] passed through unmodified.
- Reset mid-stall: hold contents discarded, BOOT re-entered.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs bubble_cnt[31:0] (cycles with valid_X=0 outside BOOT/reset) and stall_cnt[31:0] (cycles with cwe2=0). Both clear on reset, wrap at 2^32.
- Undefined: both ports present, tied to 0, no counter flops.

Test Plan:
- Reset release, memory holds sequential words → imem_addr 0,4,8 on successive cycles; inst_X of pc 0 valid on 2nd edge; valid_X=0 during BOOT.
- cwe2=0 for 3 cycles at pc_F=0x10 → imem_re=0 for 3 cycles; inst_X holds mem[0x10] while bus is corrupted; pc_F=0x10 throughout; resumes at 0x14.
- redirect=1, noop=1, redirect_pc=0x200 at pc_F=0x40 → next cycle inst_X=0x13, valid_X=0; following cycle inst_X=mem[0x200], pc_X=0x200.
- Load-use: cwe2=0, noop=1 at pc_F=0x20 → one NOP with valid_X=0, then mem[0x20] with pc_X=0x20, valid_X=1, no refetch.
- rst pulsed low during HOLD → outputs immediately NOP/valid 0; refetch from RESET_PC.
- FETCH_PERF_CNT_EN defined, run previous two scenarios → stall_cnt=1, bubble_cnt=1 after load-use.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Synchronous instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, output imem_re, input imem_rdata);
  modport slave  (input imem_addr, input imem_re, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, bubble injection and one-entry hold buffer.
// Optional FETCH_PERF_CNT_EN adds bubble/stall cycle counters (ports tied to 0 otherwise).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cwe2,
  input  logic          noop,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   inst_X,
  output logic [31:0]   pc_X,
  output logic          valid_X,
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  // Set when hold_q owns the word for pc_q, so leaving KILL must not refetch it
  logic        kill_hold_q, kill_hold_d;

  logic [31:0] next_pc;
  logic [31:0] addr;
  logic        re;
  logic [31:0] inst;
  logic        vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      hold_q      <= NOP_INST;
      kill_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      kill_hold_q <= kill_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    kill_hold_d = kill_hold_q;
    addr        = pc_q;
    re          = 1'b0;
    inst        = NOP_INST;
    vld         = 1'b0;
    next_pc     = redirect ? redirect_pc : pc_q + 32'd4;

    case (state_q)
      BOOT: begin
        addr    = RESET_PC;
        re      = 1'b1;
        state_d = RUN;
      end
      RUN, HOLD: begin
        inst = (state_q == RUN) ? imem.imem_rdata : hold_q;
        vld  = 1'b1;
        if (cwe2) begin
          addr        = next_pc;
          re          = 1'b1;
          pc_d        = next_pc;
          kill_hold_d = 1'b0;
          state_d     = noop ? KILL : RUN;
        end else begin
          if (state_q == RUN) hold_d = imem.imem_rdata;
          kill_hold_d = 1'b1;
          state_d     = noop ? KILL : HOLD;
        end
      end
      default: begin
        // The word for pc_q is either in flight (re-read it) or parked in hold_q
        if (cwe2 && (redirect || !kill_hold_q)) begin
          addr        = redirect ? redirect_pc : pc_q;
          re          = 1'b1;
          pc_d        = redirect ? redirect_pc : pc_q;
          kill_hold_d = 1'b0;
          state_d     = noop ? KILL : RUN;
        end else begin
          if (!kill_hold_q) hold_d = imem.imem_rdata;
          kill_hold_d = 1'b1;
          state_d     = noop ? KILL : HOLD;
        end
      end
    endcase
  end

  assign imem.imem_addr = addr;
  assign imem.imem_re   = re & rst;
  assign inst_X         = inst;
  assign pc_X           = pc_q;
  assign valid_X        = vld & rst;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + ((state_q == KILL) ? 32'd1 : 32'd0);
    stall_cnt_d  = stall_cnt_q + (cwe2 ? 32'd0 : 32'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign bubble_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors queued by the driver, checked by a monitor.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        cwe2;
  logic        noop;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_X;
  logic [31:0] pc_X;
  logic        valid_X;
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .cwe2        (cwe2),
    .noop        (noop),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .inst_X      (inst_X),
    .pc_X        (pc_X),
    .valid_X     (valid_X),
    .bubble_cnt  (bubble_cnt),
    .stall_cnt   (stall_cnt)
  );

`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] EXP_LU_CNT = 32'd1;
`else
  localparam logic [31:0] EXP_LU_CNT = 32'd0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        vld;
    logic        re;
    logic [31:0] addr;
    int          cc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at address a is {16'hC0DE, a[15:0]}; unread cycles return garbage
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_re ? {16'hC0DE, bus.imem_addr[15:0]} : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "inst_X", inst_X, e.inst);
      chk(e.nm, "pc_X", pc_X, e.pc);
      chk(e.nm, "valid_X", {31'd0, valid_X}, {31'd0, e.vld});
      chk(e.nm, "imem_re", {31'd0, bus.imem_re}, {31'd0, e.re});
      chk(e.nm, "imem_addr", bus.imem_addr, e.addr);
      if (e.cc != 0) begin
        chk(e.nm, "bubble_cnt", bubble_cnt, (e.cc == 2) ? EXP_LU_CNT : 32'd0);
        chk(e.nm, "stall_cnt", stall_cnt, (e.cc == 2) ? EXP_LU_CNT : 32'd0);
      end
    end
  end

  task automatic step(input logic c, input logic n, input logic r, input logic [31:0] rpc,
                      input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                      input logic er, input logic [31:0] ea, input int cc, input string nm);
    exp_t e;
    cwe2        = c;
    noop        = n;
    redirect    = r;
    redirect_pc = rpc;
    e.nm = nm; e.inst = ei; e.pc = ep; e.vld = ev; e.re = er; e.addr = ea; e.cc = cc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cwe2 = 1'b1; noop = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    @(posedge clk);
    #1;
    //     cwe2 noop redir rpc            inst          pc            v     re    addr          cc
    step(1, 0, 0, 32'h0,          32'h13,       32'h0,        1'b0, 1'b0, 32'h0,        1, "reset");
    rst = 1'b1;
    step(1, 0, 0, 32'h0,          32'h13,       32'h0,        1'b0, 1'b1, 32'h0,        1, "boot");
    step(1, 0, 0, 32'h0,          32'hC0DE0000, 32'h0,        1'b1, 1'b1, 32'h4,        0, "run0");
    step(1, 0, 0, 32'h0,          32'hC0DE0004, 32'h4,        1'b1, 1'b1, 32'h8,        0, "run4");
    step(1, 0, 0, 32'h0,          32'hC0DE0008, 32'h8,        1'b1, 1'b1, 32'hC,        0, "run8");
    step(1, 0, 0, 32'h0,          32'hC0DE000C, 32'hC,        1'b1, 1'b1, 32'h10,       0, "runC");
    step(0, 0, 0, 32'h0,          32'hC0DE0010, 32'h10,       1'b1, 1'b0, 32'h10,       0, "stall1");
    step(0, 0, 0, 32'h0,          32'hC0DE0010, 32'h10,       1'b1, 1'b0, 32'h10,       0, "stall2");
    step(0, 0, 0, 32'h0,          32'hC0DE0010, 32'h10,       1'b1, 1'b0, 32'h10,       0, "stall3");
    step(1, 0, 0, 32'h0,          32'hC0DE0010, 32'h10,       1'b1, 1'b1, 32'h14,       0, "release");
    step(1, 0, 0, 32'h0,          32'hC0DE0014, 32'h14,       1'b1, 1'b1, 32'h18,       0, "resume14");
    step(1, 0, 0, 32'h0,          32'hC0DE0018, 32'h18,       1'b1, 1'b1, 32'h1C,       0, "run18");
    step(1, 0, 0, 32'h0,          32'hC0DE001C, 32'h1C,       1'b1, 1'b1, 32'h20,       0, "run1C");
    step(0, 1, 0, 32'h0,          32'hC0DE0020, 32'h20,       1'b1, 1'b0, 32'h20,       0, "ldu_req");
    step(1, 0, 0, 32'h0,          32'h13,       32'h20,       1'b0, 1'b0, 32'h20,       0, "ldu_nop");
    step(1, 0, 0, 32'h0,          32'hC0DE0020, 32'h20,       1'b1, 1'b1, 32'h24,       0, "ldu_held");
    step(1, 0, 0, 32'h0,          32'hC0DE0024, 32'h24,       1'b1, 1'b1, 32'h28,       0, "run24");
    step(1, 0, 0, 32'h0,          32'hC0DE0028, 32'h28,       1'b1, 1'b1, 32'h2C,       0, "run28");
    step(1, 0, 0, 32'h0,          32'hC0DE002C, 32'h2C,       1'b1, 1'b1, 32'h30,       0, "run2C");
    step(1, 0, 0, 32'h0,          32'hC0DE0030, 32'h30,       1'b1, 1'b1, 32'h34,       0, "run30");
    step(1, 0, 0, 32'h0,          32'hC0DE0034, 32'h34,       1'b1, 1'b1, 32'h38,       0, "run34");
    step(1, 0, 0, 32'h0,          32'hC0DE0038, 32'h38,       1'b1, 1'b1, 32'h3C,       0, "run38");
    step(1, 0, 0, 32'h0,          32'hC0DE003C, 32'h3C,       1'b1, 1'b1, 32'h40,       0, "run3C");
    step(1, 1, 1, 32'h200,        32'hC0DE0040, 32'h40,       1'b1, 1'b1, 32'h200,      0, "redir_req");
    step(1, 0, 0, 32'h0,          32'h13,       32'h200,      1'b0, 1'b1, 32'h200,      0, "redir_nop");
    step(1, 0, 1, 32'h303,        32'hC0DE0200, 32'h200,      1'b1, 1'b1, 32'h303,      0, "redir_tgt");
    step(1, 0, 1, 32'hFFFFFFFC,   32'hC0DE0303, 32'h303,      1'b1, 1'b1, 32'hFFFFFFFC, 0, "misalign");
    step(1, 0, 0, 32'h0,          32'hC0DEFFFC, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h0,        0, "wrap");
    step(1, 0, 0, 32'h0,          32'hC0DE0000, 32'h0,        1'b1, 1'b1, 32'h4,        0, "after_wrap");
    step(0, 0, 0, 32'h0,          32'hC0DE0004, 32'h4,        1'b1, 1'b0, 32'h4,        0, "hold_a");
    step(0, 0, 0, 32'h0,          32'hC0DE0004, 32'h4,        1'b1, 1'b0, 32'h4,        0, "hold_b");
    rst = 1'b0;
    step(0, 0, 0, 32'h0,          32'h13,       32'h0,        1'b0, 1'b0, 32'h0,        1, "rst_in_hold");
    rst = 1'b1;
    step(1, 0, 0, 32'h0,          32'h13,       32'h0,        1'b0, 1'b1, 32'h0,        1, "reboot");
    step(1, 0, 0, 32'h0,          32'hC0DE0000, 32'h0,        1'b1, 1'b1, 32'h4,        0, "refetch0");
    step(0, 1, 0, 32'h0,          32'hC0DE0004, 32'h4,        1'b1, 1'b0, 32'h4,        0, "ldu2_req");
    step(1, 0, 0, 32'h0,          32'h13,       32'h4,        1'b0, 1'b0, 32'h4,        0, "ldu2_nop");
    step(1, 0, 0, 32'h0,          32'hC0DE0004, 32'h4,        1'b1, 1'b1, 32'h8,        0, "ldu2_held");
    step(1, 0, 0, 32'h0,          32'hC0DE0008, 32'h8,        1'b1, 1'b1, 32'hC,        2, "perf_cnt");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
